// File: rtl/mem_stack_responder.sv
// Services one control-path request: an optional load from mem/stk, then an optional store.
// Optional build macro ACCESS_FAULT_EN: out-of-range addresses fault and suppress the access.
module mem_stack_responder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned STK_AW = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_load_src,
  input  logic              req_store_mem,
  input  logic              req_store_stk,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STK_AW-1:0] stk_addr,
  output logic [DATA_W-1:0] stk_wdata,
  output logic              stk_we,
  input  logic [DATA_W-1:0] stk_rdata
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          load_src_q;
  logic                store_mem_q, store_stk_q;
  logic [DATA_W-1:0]   addr_q, wdata_q;

  logic accept;
  logic mem_oob, stk_oob;
  logic load_en, load_oob, store_oob, dual_store, store_any;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

`ifdef ACCESS_FAULT_EN
  assign mem_oob = (addr_q >> MEM_AW) != '0;
  assign stk_oob = (addr_q >> STK_AW) != '0;
`else
  localparam int unsigned AddrMax = (MEM_AW > STK_AW) ? MEM_AW : STK_AW;
  // Upper address bits are deliberately dropped (wrap-around addressing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[DATA_W-1:AddrMax];
  assign mem_oob = 1'b0;
  assign stk_oob = 1'b0;
`endif

  assign load_en    = load_src_q[1];
  assign load_oob   = load_en & (load_src_q[0] ? stk_oob : mem_oob);
  assign dual_store = store_mem_q & store_stk_q;
  assign store_any  = store_mem_q | store_stk_q;
  assign store_oob  = (store_mem_q & mem_oob) | (store_stk_q & stk_oob);

  // Next-state, read-window counter and load-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_load_src[1]) begin
            state_d = StRead;
          end else if (req_store_mem | req_store_stk) begin
            state_d = StWrite;
          end else begin
            state_d = StResp;
          end
        end
      end
      StRead: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          rdata_d = load_oob ? '0 : (load_src_q[0] ? stk_rdata : mem_rdata);
          state_d = store_any ? StWrite : StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RAM port drive; write enables are gated by resetn so no write can land during reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    stk_addr  = '0;
    stk_wdata = '0;
    stk_we    = 1'b0;
    if (state_q == StRead || state_q == StWrite) begin
      mem_addr = addr_q[MEM_AW-1:0];
      stk_addr = addr_q[STK_AW-1:0];
    end
    if (state_q == StWrite) begin
      mem_wdata = wdata_q;
      stk_wdata = wdata_q;
      mem_we    = resetn & store_mem_q & ~store_stk_q & ~mem_oob;
      stk_we    = resetn & store_stk_q & ~store_mem_q & ~stk_oob;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_fault = rsp_valid & (dual_store | load_oob | store_oob);
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rdata_q     <= '0;
      load_src_q  <= 2'b00;
      store_mem_q <= 1'b0;
      store_stk_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        load_src_q  <= req_load_src;
        store_mem_q <= req_store_mem;
        store_stk_q <= req_store_stk;
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
      end
    end
  end

endmodule
